// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: register address width, scoreboard entry layout
// and the encoding of the operand forward selects.
package pipeline_pkg;

    localparam int REG_AW = 5;

    typedef struct packed {
        logic              valid;
        logic              wr;
        logic              ld;
        logic [REG_AW-1:0] dest;
    } sb_entry_t;

    localparam int unsigned FWD_RF  = 32'd0;
    localparam int unsigned FWD_EXE = 32'd1;
    localparam int unsigned FWD_MEM = 32'd2;
    localparam int unsigned FWD_WB  = 32'd3;

endpackage

// File: rtl/hazard_match.sv
// Combinational priority finder: locates the youngest in-flight writer of one
// source register and reports whether that writer is a load still in EXE.
module hazard_match
    import pipeline_pkg::*;
#(
    parameter int REG_AW    = pipeline_pkg::REG_AW,
    parameter int DEPTH     = 3,
    parameter int RF_BYPASS = 1,
    parameter int SELW      = $clog2(DEPTH + 1)
) (
    input  logic [DEPTH-1:0]        valid,
    input  logic [DEPTH-1:0]        wr,
    input  logic                    ld1,
    input  logic [DEPTH*REG_AW-1:0] dest,
    input  logic [REG_AW-1:0]       src,
    input  logic                    check,
    output logic                    hit,
    output logic                    ld_hit,
    output logic [SELW-1:0]         sel
);

    logic [DEPTH-1:0] match_s;
    logic             hit_s;
    logic             ld_hit_s;
    logic [SELW-1:0]  sel_s;

    // Per-entry match; a write-first register file makes the oldest entry harmless
    always_comb begin
        match_s = {DEPTH{1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            match_s[k] = check && (src != {REG_AW{1'b0}}) && valid[k] && wr[k]
                         && (dest[k*REG_AW +: REG_AW] == src)
                         && !((RF_BYPASS != 0) && (k == DEPTH - 1));
        end
    end

    // Scan oldest to youngest so the youngest matching entry overwrites the select
    always_comb begin
        hit_s    = 1'b0;
        ld_hit_s = 1'b0;
        sel_s    = SELW'(FWD_RF);
        for (int k = DEPTH - 1; k >= 0; k--) begin
            hit_s = hit_s | match_s[k];
            sel_s = match_s[k] ? SELW'(k + 1) : sel_s;
        end
        ld_hit_s = match_s[FWD_EXE - 1] & ld1;
    end

    assign hit    = hit_s;
    assign ld_hit = ld_hit_s;
    assign sel    = sel_s;

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding controller beside ID: tracks in-flight destinations,
// raises load-use/RAW stalls, branch flushes, forward selects and perf counters.
module hazard_scoreboard
    import pipeline_pkg::*;
#(
    parameter int REG_AW    = pipeline_pkg::REG_AW,
    parameter int DEPTH     = 3,
    parameter int FWD_EN    = 1,
    parameter int RF_BYPASS = 1,
    parameter int CNT_W     = 32,
    localparam int SELW     = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_src1,
    input  logic [REG_AW-1:0] id_src2,
    input  logic              id_src2_used,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              id_wb_en,
    input  logic              id_mem_read,
    input  logic              branch_taken,
    output logic              stall,
    output logic              ifid_flush,
    output logic              idexe_flush,
    output logic [SELW-1:0]   fwd_sel1,
    output logic [SELW-1:0]   fwd_sel2,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    // The load flag only matters while the load sits in EXE, so only entry 1 keeps it
    logic [DEPTH-1:0]        valid_r;
    logic [DEPTH-1:0]        wr_r;
    logic                    ld1_r;
    logic [DEPTH*REG_AW-1:0] dest_r;
    logic [CNT_W-1:0]        stall_count_r;
    logic [CNT_W-1:0]        flush_count_r;

    logic                    load_s;
    logic                    hit1_s, hit2_s;
    logic                    ld_hit1_s, ld_hit2_s;
    logic [SELW-1:0]         msel1_s, msel2_s;
    logic                    stall_raw_s;
    logic                    stall_s;
    logic [SELW-1:0]         sel1_s, sel2_s;

    hazard_match #(
        .REG_AW    (REG_AW),
        .DEPTH     (DEPTH),
        .RF_BYPASS (RF_BYPASS),
        .SELW      (SELW)
    ) u_match1 (
        .valid  (valid_r),
        .wr     (wr_r),
        .ld1    (ld1_r),
        .dest   (dest_r),
        .src    (id_src1),
        .check  (id_valid),
        .hit    (hit1_s),
        .ld_hit (ld_hit1_s),
        .sel    (msel1_s)
    );

    hazard_match #(
        .REG_AW    (REG_AW),
        .DEPTH     (DEPTH),
        .RF_BYPASS (RF_BYPASS),
        .SELW      (SELW)
    ) u_match2 (
        .valid  (valid_r),
        .wr     (wr_r),
        .ld1    (ld1_r),
        .dest   (dest_r),
        .src    (id_src2),
        .check  (id_valid & id_src2_used),
        .hit    (hit2_s),
        .ld_hit (ld_hit2_s),
        .sel    (msel2_s)
    );

    // Stall policy: load-use only when forwarding, any RAW match otherwise
    always_comb begin
        if (FWD_EN != 0) begin
            stall_raw_s = ld_hit1_s | ld_hit2_s;
            sel1_s      = msel1_s;
            sel2_s      = msel2_s;
        end else begin
            stall_raw_s = hit1_s | hit2_s;
            sel1_s      = SELW'(FWD_RF);
            sel2_s      = SELW'(FWD_RF);
        end
    end

    // A taken branch kills the ID instruction, so its hazard is irrelevant
    assign stall_s = stall_raw_s & ~branch_taken;
    assign load_s  = id_valid & ~stall_s & ~branch_taken;

    // Entry shift register; later stages always advance, entry 1 takes ID or a bubble
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_r <= {DEPTH{1'b0}};
            wr_r    <= {DEPTH{1'b0}};
            ld1_r   <= 1'b0;
            dest_r  <= {(DEPTH*REG_AW){1'b0}};
        end else begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                valid_r[k]                 <= valid_r[k-1];
                wr_r[k]                    <= wr_r[k-1];
                dest_r[k*REG_AW +: REG_AW] <= dest_r[(k-1)*REG_AW +: REG_AW];
            end
            valid_r[0]           <= load_s;
            wr_r[0]              <= load_s & id_wb_en & (id_dest != {REG_AW{1'b0}});
            ld1_r                <= load_s & id_mem_read;
            dest_r[0 +: REG_AW]  <= load_s ? id_dest : {REG_AW{1'b0}};
        end
    end

    // Free-running performance counters, wrapping modulo 2^CNT_W
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_count_r <= {CNT_W{1'b0}};
            flush_count_r <= {CNT_W{1'b0}};
        end else begin
            stall_count_r <= stall_s ? stall_count_r + {{(CNT_W-1){1'b0}}, 1'b1} : stall_count_r;
            flush_count_r <= branch_taken ? flush_count_r + {{(CNT_W-1){1'b0}}, 1'b1} : flush_count_r;
        end
    end

    assign stall       = stall_s;
    assign ifid_flush  = branch_taken;
    assign idexe_flush = branch_taken;
    assign fwd_sel1    = sel1_s;
    assign fwd_sel2    = sel2_s;
    assign stall_count = stall_count_r;
    assign flush_count = flush_count_r;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: instance A (forwarding) driven from a vector table, instance B
// (stall-only, 2-bit counters) checked with hand-written multi-cycle sequences.
module tb_hazard_scoreboard;

    logic       clock = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_src1, id_src2, id_dest;
    logic       id_src2_used, id_wb_en, id_mem_read, branch_taken;

    logic        stall_a, ifid_a, idexe_a;
    logic [1:0]  sel1_a, sel2_a;
    logic [31:0] scnt_a, fcnt_a;
    logic        stall_b, ifid_b, idexe_b;
    logic [1:0]  sel1_b, sel2_b;
    logic [1:0]  scnt_b, fcnt_b;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    hazard_scoreboard #(.REG_AW(5), .DEPTH(3), .FWD_EN(1), .RF_BYPASS(1), .CNT_W(32)) dut_a (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_src1(id_src1),
        .id_src2(id_src2), .id_src2_used(id_src2_used), .id_dest(id_dest),
        .id_wb_en(id_wb_en), .id_mem_read(id_mem_read), .branch_taken(branch_taken),
        .stall(stall_a), .ifid_flush(ifid_a), .idexe_flush(idexe_a),
        .fwd_sel1(sel1_a), .fwd_sel2(sel2_a), .stall_count(scnt_a), .flush_count(fcnt_a)
    );

    hazard_scoreboard #(.REG_AW(5), .DEPTH(3), .FWD_EN(0), .RF_BYPASS(1), .CNT_W(2)) dut_b (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_src1(id_src1),
        .id_src2(id_src2), .id_src2_used(id_src2_used), .id_dest(id_dest),
        .id_wb_en(id_wb_en), .id_mem_read(id_mem_read), .branch_taken(branch_taken),
        .stall(stall_b), .ifid_flush(ifid_b), .idexe_flush(idexe_b),
        .fwd_sel1(sel1_b), .fwd_sel2(sel2_b), .stall_count(scnt_b), .flush_count(fcnt_b)
    );

    typedef struct {
        logic       vld;
        logic [4:0] s1;
        logic [4:0] s2;
        logic       s2u;
        logic [4:0] dst;
        logic       wb;
        logic       mr;
        logic       br;
        logic       e_stall;
        logic       e_flush;
        logic [1:0] e_sel1;
        logic [1:0] e_sel2;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic vld, input logic [4:0] s1, input logic [4:0] s2,
                         input logic s2u, input logic [4:0] dst, input logic wb,
                         input logic mr, input logic br);
        id_valid     = vld;
        id_src1      = s1;
        id_src2      = s2;
        id_src2_used = s2u;
        id_dest      = dst;
        id_wb_en     = wb;
        id_mem_read  = mr;
        branch_taken = br;
    endtask

    initial begin
        //            vld  s1     s2     s2u   dst    wb    mr    br    stall flush sel1   sel2
        vecs[0]  = '{1'b0, 5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
        vecs[1]  = '{1'b1, 5'd0,  5'd0,  1'b0, 5'd2,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
        vecs[2]  = '{1'b1, 5'd2,  5'd0,  1'b0, 5'd6,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 2'd0};
        vecs[3]  = '{1'b1, 5'd2,  5'd0,  1'b0, 5'd6,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0};
        vecs[4]  = '{1'b1, 5'd0,  5'd0,  1'b0, 5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
        vecs[5]  = '{1'b1, 5'd7,  5'd3,  1'b1, 5'd8,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1};
        vecs[6]  = '{1'b1, 5'd6,  5'd3,  1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2};
        vecs[7]  = '{1'b1, 5'd8,  5'd3,  1'b1, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0};
        vecs[8]  = '{1'b1, 5'd0,  5'd0,  1'b0, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
        vecs[9]  = '{1'b1, 5'd5,  5'd5,  1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0};
        vecs[10] = '{1'b1, 5'd0,  5'd0,  1'b1, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
        vecs[11] = '{1'b1, 5'd0,  5'd0,  1'b0, 5'd9,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};
        vecs[12] = '{1'b1, 5'd9,  5'd0,  1'b0, 5'd12, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 2'd0};
        vecs[13] = '{1'b1, 5'd9,  5'd0,  1'b0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0};
        vecs[14] = '{1'b0, 5'd10, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0};

        reset = 1'b1;
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #2;
        chk("reset_stall_count_a", scnt_a, 32'd0);
        chk("reset_flush_count_a", fcnt_a, 32'd0);
        chk("reset_stall_b", {31'd0, stall_b}, 32'd0);

        // Table phase on the forwarding instance; inputs change on the falling edge
        for (int i = 0; i < NV; i++) begin
            @(negedge clock);
            drive(vecs[i].vld, vecs[i].s1, vecs[i].s2, vecs[i].s2u,
                  vecs[i].dst, vecs[i].wb, vecs[i].mr, vecs[i].br);
            #2;
            chk($sformatf("v%0d_stall", i), {31'd0, stall_a}, {31'd0, vecs[i].e_stall});
            chk($sformatf("v%0d_ifid_flush", i), {31'd0, ifid_a}, {31'd0, vecs[i].e_flush});
            chk($sformatf("v%0d_idexe_flush", i), {31'd0, idexe_a}, {31'd0, vecs[i].e_flush});
            chk($sformatf("v%0d_fwd_sel1", i), {30'd0, sel1_a}, {30'd0, vecs[i].e_sel1});
            chk($sformatf("v%0d_fwd_sel2", i), {30'd0, sel2_a}, {30'd0, vecs[i].e_sel2});
        end
        @(negedge clock);
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #2;
        chk("table_stall_count_a", scnt_a, 32'd1);
        chk("table_flush_count_a", fcnt_a, 32'd1);

        // Stall-only instance: clean restart
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #2;
        chk("rst2_stall_count_a", scnt_a, 32'd0);
        chk("rst2_flush_count_a", fcnt_a, 32'd0);
        chk("rst2_stall_count_b", {30'd0, scnt_b}, 32'd0);

        // Write r4 then read r4: stall while it sits in entries 1 and 2
        drive(1'b1, 5'd0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
        #2;
        chk("b_write_stall", {31'd0, stall_b}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            drive(1'b1, 5'd4, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0);
            #2;
            chk($sformatf("b_raw_stall_c%0d", c), {31'd0, stall_b}, (c < 2) ? 32'd1 : 32'd0);
            chk($sformatf("b_raw_sel1_c%0d", c), {30'd0, sel1_b}, 32'd0);
        end
        chk("b_stall_count", {30'd0, scnt_b}, 32'd2);

        // Same hazard again, with reset landing on the stalled cycle
        @(negedge clock);
        drive(1'b1, 5'd0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0);
        @(negedge clock);
        drive(1'b1, 5'd4, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        #2;
        chk("b_pre_reset_stall", {31'd0, stall_b}, 32'd1);
        @(negedge clock);
        reset = 1'b0;
        #2;
        chk("b_post_reset_stall", {31'd0, stall_b}, 32'd0);
        chk("b_post_reset_stall_count", {30'd0, scnt_b}, 32'd0);
        chk("b_post_reset_flush_count", {30'd0, fcnt_b}, 32'd0);
        chk("a_post_reset_sel1", {30'd0, sel1_a}, 32'd0);
        chk("a_post_reset_stall", {31'd0, stall_a}, 32'd0);

        // Five taken branches: 2-bit counter wraps to 1, 32-bit counter reads 5
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
            #2;
            chk($sformatf("br_flush_b_c%0d", c), {31'd0, ifid_b & idexe_b}, 32'd1);
        end
        @(negedge clock);
        drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #2;
        chk("wrap_flush_count_b", {30'd0, fcnt_b}, 32'd1);
        chk("flush_count_a_5", fcnt_a, 32'd5);
        chk("stall_count_a_0", scnt_a, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard and forwarding controller for the in-order pipeline. It sits beside the ID stage.
- It tracks the destinations of in-flight instructions in a DEPTH-entry shift register (entry 1 = EXE … entry DEPTH = last writeback stage).
- It generates the load-use/RAW stall, branch flush controls and per-operand forwarding selects.
- Successor to the fixed 5-stage flush-only control: adds configurable depth, a forwarding/stall-only mode, a register-file bypass mode and performance counters.

Parameters:
REG_AW, 5, register address width
DEPTH, 3, tracked stages after ID (EXE, MEM, WB)
FWD_EN, 1, 1 = forward from tracked stages; 0 = stall on any RAW match
RF_BYPASS, 1, 1 = register file is write-first, so the last stage never causes a hazard
CNT_W, 32, performance counter width
SELW, $clog2(DEPTH+1), forward select width (derived localparam)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
id_valid  in  1  ID holds a real instruction
id_src1  in  REG_AW  first source register
id_src2  in  REG_AW  second source register
id_src2_used  in  1  src2 is read (not immediate-only)
id_dest  in  REG_AW  destination register
id_wb_en  in  1  instruction writes the register file
id_mem_read  in  1  instruction is a load
branch_taken  in  1  branch resolved taken in EXE this cycle
stall  out  1  hold PC and IF/ID; inject bubble into ID/EXE
ifid_flush  out  1  clear IF/ID
idexe_flush  out  1  insert bubble into ID/EXE
fwd_sel1  out  SELW  0 = register file, k = forward from entry k
fwd_sel2  out  SELW  same, for src2
stall_count  out  CNT_W  cycles with stall asserted
flush_count  out  CNT_W  cycles with branch_taken asserted

Behaviour:
- Interface: one clock `clock`; reset `reset` is synchronous and active-high.
- Entry fields: valid, wr (wb_en and dest != 0), ld (mem_read), dest.
- On reset: all entries cleared; both counters 0. Outputs after reset are stall=0, flushes=0, fwd_sel=0.
- Every cycle, entry k takes entry k-1 for k = 2..DEPTH. Entries never stall (stages after ID always advance).
- Entry 1 loads {1, id_wb_en & (id_dest != 0), id_mem_read, id_dest} when id_valid & ~stall & ~branch_taken. Otherwise it loads a bubble (all zero).
- Match(k, r): entry k valid & wr & dest == r & r != 0. r=0 never matches.
- When RF_BYPASS=1, entry DEPTH is excluded from match.
- A source is checked only if used: src1 is always checked; src2 only when id_src2_used. Checks apply only when id_valid.
- FWD_EN=1:
  - stall = any used source matches entry 1 with ld=1 (load-use).
  - fwd_selN = smallest k with Match(k, srcN), i.e. the youngest wins; 0 if none.
- FWD_EN=0: stall = any used source matches any eligible entry; fwd_sel1 = fwd_sel2 = 0 constant.
- Flush: ifid_flush = idexe_flush = branch_taken.
  - Flush has priority: when branch_taken=1, stall is forced to 0 because the ID instruction is being killed.
- Outputs stall, flushes and fwd_sel are combinational from the current entries and ID inputs. Zero-cycle latency.
- Counters increment by 1 on cycles where their condition holds. They wrap at 2^CNT_W modulo.
- Reset mid-operation clears all in-flight entries in one cycle. The first post-reset instruction sees no hazard.
- Stall repeats each cycle while the hazard persists. With FWD_EN=1 a load-use stall lasts exactly 1 cycle: the bubble advances the load to entry 2, where it is forwarded.

Decomposition:
- Shared package pipeline_pkg:
  - REG_AW default, the scoreboard entry struct (valid, wr, ld, dest);
  - forward-select encoding constants FWD_RF=0, FWD_EXE=1, FWD_MEM=2, FWD_WB=3.
- One sub-module is natural: hazard_match, the combinational priority finder. It is instantiated twice (src1, src2) and returns a match flag, the load-at-entry-1 flag and the select.

Test Plan:
- Reset, then a load to r2 at ID (id_mem_read=1, dest=2), next a read of r2 in src1 (FWD_EN=1) -> stall=1 for exactly 1 cycle, then fwd_sel1=2; stall_count=1.
- ALU write r3 followed immediately by read r3 on src2 with src2_used=1 -> stall=0, fwd_sel2=1. The same read one instruction later gives fwd_sel2=2.
- Write r5 in two consecutive instructions, then read r5 -> fwd_sel1=1 (youngest wins, not 2).
- Source r0 with an in-flight write to r0 (id_dest=0, wb_en=1) -> no stall, fwd_sel=0.
- branch_taken=1 while ID has a load-use hazard -> stall=0, ifid_flush=idexe_flush=1, entry 1 becomes a bubble; flush_count increments by 1.
- FWD_EN=0, DEPTH=3, RF_BYPASS=1: write r4 then read r4 -> stall for 2 cycles (entries 1, 2), released when the write reaches entry 3. Assert reset in the middle of this -> stall drops the cycle after reset, counters read 0.
